hazard_ctrl_unit: RTL and testbench

// - Next-generation hazard unit for the 5-stage ARM pipeline (F/D/E/M/W).
// - Generates forwarding selects, load-use and PC-write stalls, and D/E/W flushes.
// - Adds variable-latency data-memory stall handling with a timeout FSM.
// - Adds saturating stall/flush performance counters.
// - Sits beside the control and data paths; all control outputs are combinational from current stage state.

---
 rtl/hazard_ctrl_unit_pkg.sv | 17 +
 rtl/hazard_ctrl_unit_fwd_select.sv | 31 +++
 rtl/hazard_ctrl_unit.sv | 136 +++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types for the pipeline hazard unit: forwarding selects and the
// data-memory wait FSM state encoding.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } mem_st_t;

endpackage

// File: rtl/hazard_ctrl_unit_fwd_select.sv
// Forwarding select for one E-stage read port: the newest in-flight producer
// (M before W) wins, and the PC register is always read from the register file.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int AW     = 4,
  parameter int PC_REG = 15
) (
  input  logic [AW-1:0] ra_e,
  input  logic [AW-1:0] wa3_m,
  input  logic [AW-1:0] wa3_w,
  input  logic          reg_write_m,
  input  logic          reg_write_w,
  output fwd_sel_t      fwd_sel
);

  logic not_pc;
  assign not_pc = (ra_e != AW'(PC_REG));

  always_comb begin
    // NOTE: assigning a default before any branch keeps this block purely
    // combinational; a missing else on a comb output would infer a latch.
    fwd_sel = FWD_RF;
    if (reg_write_m && (ra_e == wa3_m) && not_pc) begin
      fwd_sel = FWD_M;
    end else if (reg_write_w && (ra_e == wa3_w) && not_pc) begin
      fwd_sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard unit for the F/D/E/M/W pipeline: forwarding, load-use and PC-write
// stalls, flushes, a data-memory wait/timeout FSM and saturating perf counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int AW     = 4,
  parameter int NUM_RP = 2,
  parameter int PC_REG = 15,
  parameter int MEM_TO = 16,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AW-1:0]        RA1D,
  input  logic [AW-1:0]        RA2D,
  input  logic [NUM_RP*AW-1:0] RAE,
  input  logic [AW-1:0]        WA3E,
  input  logic [AW-1:0]        WA3M,
  input  logic [AW-1:0]        WA3W,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 MemtoRegE,
  input  logic                 PCSrcD,
  input  logic                 PCSrcE,
  input  logic                 PCSrcM,
  input  logic                 PCSrcW,
  input  logic                 BranchTakenE,
  input  logic                 MemBusyM,
  output logic [NUM_RP*2-1:0]  ForwardE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushW,
  output logic                 MemErr,
  output logic [CNT_W-1:0]     StallCnt,
  output logic [CNT_W-1:0]     FlushCnt
);

  localparam int WCW = $clog2(MEM_TO + 1);

  for (genvar i = 0; i < NUM_RP; i++) begin : g_fwd
    fwd_sel_t sel;
    fwd_select #(.AW(AW), .PC_REG(PC_REG)) u_fwd (
      .ra_e        (RAE[i*AW +: AW]),
      .wa3_m       (WA3M),
      .wa3_w       (WA3W),
      .reg_write_m (RegWriteM),
      .reg_write_w (RegWriteW),
      .fwd_sel     (sel)
    );
    assign ForwardE[i*2 +: 2] = sel;
  end

  mem_st_t          state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             mem_stall, ldr_stall, pc_wr_pend;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    if (reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // The wait counter holds the number of busy cycles already absorbed.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (MemBusyM) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WCW'(1);
        end
      end
      MEM_WAIT: begin
        if (!MemBusyM) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WCW'(MEM_TO)) begin
          state_d = ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    mem_stall = MemBusyM;
    MemErr    = 1'b0;
    if (state_q == ERR) begin
      mem_stall = 1'b1;
      MemErr    = 1'b1;
    end
  end

  assign ldr_stall  = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));
  assign pc_wr_pend = PCSrcD || PCSrcE || PCSrcM;

  // A held memory stage freezes everything upstream, so D/E flushes wait.
  assign StallM = mem_stall;
  assign StallE = mem_stall;
  assign StallD = mem_stall || ldr_stall;
  assign StallF = mem_stall || ldr_stall || pc_wr_pend;
  assign FlushW = mem_stall;
  assign FlushE = !mem_stall && (ldr_stall || BranchTakenE);
  assign FlushD = !mem_stall && (pc_wr_pend || PCSrcW || BranchTakenE);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    if ((FlushD || FlushE) && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench: a default instance and a small one (MEM_TO=4, CNT_W=4)
// share stimulus and are compared against a cycle-level behavioural model.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ra1d, ra2d, wa3e, wa3m, wa3w;
  logic [7:0] rae;
  logic       reg_write_m, reg_write_w, memto_reg_e;
  logic       pc_src_d, pc_src_e, pc_src_m, pc_src_w, branch_taken_e, mem_busy_m;

  logic [3:0]  fwd0, fwd1;
  logic        sf0, sd0, se0, sm0, fd0, fe0, fw0, err0;
  logic        sf1, sd1, se1, sm1, fd1, fe1, fw1, err1;
  logic [15:0] scnt0, fcnt0;
  logic [3:0]  scnt1, fcnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit dut (
    .clk(clk), .reset(reset), .RA1D(ra1d), .RA2D(ra2d), .RAE(rae),
    .WA3E(wa3e), .WA3M(wa3m), .WA3W(wa3w), .RegWriteM(reg_write_m),
    .RegWriteW(reg_write_w), .MemtoRegE(memto_reg_e), .PCSrcD(pc_src_d),
    .PCSrcE(pc_src_e), .PCSrcM(pc_src_m), .PCSrcW(pc_src_w),
    .BranchTakenE(branch_taken_e), .MemBusyM(mem_busy_m), .ForwardE(fwd0),
    .StallF(sf0), .StallD(sd0), .StallE(se0), .StallM(sm0), .FlushD(fd0),
    .FlushE(fe0), .FlushW(fw0), .MemErr(err0), .StallCnt(scnt0), .FlushCnt(fcnt0)
  );

  hazard_ctrl_unit #(.MEM_TO(4), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .RA1D(ra1d), .RA2D(ra2d), .RAE(rae),
    .WA3E(wa3e), .WA3M(wa3m), .WA3W(wa3w), .RegWriteM(reg_write_m),
    .RegWriteW(reg_write_w), .MemtoRegE(memto_reg_e), .PCSrcD(pc_src_d),
    .PCSrcE(pc_src_e), .PCSrcM(pc_src_m), .PCSrcW(pc_src_w),
    .BranchTakenE(branch_taken_e), .MemBusyM(mem_busy_m), .ForwardE(fwd1),
    .StallF(sf1), .StallD(sd1), .StallE(se1), .StallM(sm1), .FlushD(fd1),
    .FlushE(fe1), .FlushW(fw1), .MemErr(err1), .StallCnt(scnt1), .FlushCnt(fcnt1)
  );

  // ---------------- behavioural reference model ----------------
  bit m_err[2];
  int m_run[2];   // consecutive busy cycles seen at clock edges
  int m_scnt[2];
  int m_fcnt[2];

  function automatic int memto(int k);
    return (k == 0) ? 16 : 4;
  endfunction

  function automatic int cmax(int k);
    return (k == 0) ? 65535 : 15;
  endfunction

  function automatic bit f_ldr();
    return memto_reg_e && (ra1d == wa3e || ra2d == wa3e);
  endfunction

  function automatic bit f_pcp();
    return pc_src_d || pc_src_e || pc_src_m;
  endfunction

  function automatic bit f_ms(int k);
    return m_err[k] || mem_busy_m;
  endfunction

  function automatic logic [43:0] model_vec(int k);
    logic [3:0] fw;
    logic [3:0] r;
    bit ms, sf, sd, fd, fe;
    for (int p = 0; p < 2; p++) begin
      r = rae[p*4 +: 4];
      if (reg_write_m && r == wa3m && r != 4'd15)      fw[p*2 +: 2] = 2'b10;
      else if (reg_write_w && r == wa3w && r != 4'd15) fw[p*2 +: 2] = 2'b01;
      else                                             fw[p*2 +: 2] = 2'b00;
    end
    ms = f_ms(k);
    sf = ms || f_ldr() || f_pcp();
    sd = ms || f_ldr();
    fe = !ms && (f_ldr() || branch_taken_e);
    fd = !ms && (f_pcp() || pc_src_w || branch_taken_e);
    return {fw, sf, sd, ms, ms, fd, fe, ms, m_err[k], m_scnt[k][15:0], m_fcnt[k][15:0]};
  endfunction

  function automatic logic [43:0] dut_vec(int k);
    if (k == 0)
      return {fwd0, sf0, sd0, se0, sm0, fd0, fe0, fw0, err0, scnt0, fcnt0};
    return {fwd1, sf1, sd1, se1, sm1, fd1, fe1, fw1, err1, 12'd0, scnt1, 12'd0, fcnt1};
  endfunction

  function automatic int sat_inc(int v, bit inc, int mx);
    return (inc && v < mx) ? v + 1 : v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_err[k]  <= 1'b0;
        m_run[k]  <= 0;
        m_scnt[k] <= 0;
        m_fcnt[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_scnt[k] <= sat_inc(m_scnt[k], f_ms(k) || f_ldr() || f_pcp(), cmax(k));
        m_fcnt[k] <= sat_inc(m_fcnt[k], !f_ms(k) && (f_ldr() || f_pcp() || pc_src_w || branch_taken_e), cmax(k));
        if (!m_err[k]) begin
          if (mem_busy_m) begin
            m_run[k] <= m_run[k] + 1;
            if (m_run[k] + 1 > memto(k)) m_err[k] <= 1'b1;
          end else begin
            m_run[k] <= 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_idle();
    ra1d = 0; ra2d = 0; rae = 0; wa3e = 0; wa3m = 0; wa3w = 0;
    reg_write_m = 0; reg_write_w = 0; memto_reg_e = 0;
    pc_src_d = 0; pc_src_e = 0; pc_src_m = 0; pc_src_w = 0;
    branch_taken_e = 0; mem_busy_m = 0;
  endtask

  function automatic logic [3:0] rnd_reg();
    return ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
  endfunction

  task automatic drive_random(int busy_pct);
    ra1d = rnd_reg(); ra2d = rnd_reg(); rae = {rnd_reg(), rnd_reg()};
    wa3e = rnd_reg(); wa3m = rnd_reg(); wa3w = rnd_reg();
    reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
    memto_reg_e = ($urandom_range(0, 3) == 0);
    pc_src_d = ($urandom_range(0, 7) == 0); pc_src_e = ($urandom_range(0, 7) == 0);
    pc_src_m = ($urandom_range(0, 7) == 0); pc_src_w = ($urandom_range(0, 7) == 0);
    branch_taken_e = ($urandom_range(0, 5) == 0);
    mem_busy_m = ($urandom_range(0, 99) < busy_pct);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    #12;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_vec(k) !== 44'd0) begin
        errors++;
        $display("FAIL reset[%0d]: got %h expected 0", k, dut_vec(k));
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_forward();
    @(posedge clk); #1;
    wa3m = 3; reg_write_m = 1; wa3w = 3; reg_write_w = 1; rae = 8'h03;
    #1; checks++;
    if (fwd0[1:0] !== 2'b10) begin errors++; $display("FAIL fwd_m: got %b expected 10", fwd0[1:0]); end
    reg_write_m = 0;
    #1; checks++;
    if (fwd0[1:0] !== 2'b01) begin errors++; $display("FAIL fwd_w: got %b expected 01", fwd0[1:0]); end
    rae = 8'h0F; reg_write_m = 1; wa3m = 15; wa3w = 15;
    #1; checks++;
    if (fwd0[1:0] !== 2'b00) begin errors++; $display("FAIL fwd_pc: got %b expected 00", fwd0[1:0]); end
    rae = 8'h30; wa3m = 3; wa3w = 3;
    #1; checks++;
    if (fwd1 !== 4'b1000) begin errors++; $display("FAIL fwd_port1: got %b expected 1000", fwd1); end
    drive_idle();
  endtask

  task automatic test_load_use();
    @(posedge clk); #1;
    memto_reg_e = 1; wa3e = 5; ra2d = 5; ra1d = 1;
    @(negedge clk); checks++;
    if ({sf0, sd0, fe0, fd0} !== 4'b1110) begin
      errors++; $display("FAIL load_use: got SF,SD,FE,FD=%b expected 1110", {sf0, sd0, fe0, fd0});
    end
    @(posedge clk); #1;
    memto_reg_e = 0;
    @(negedge clk); checks++;
    if ({sf0, sd0, fe0, fd0} !== 4'b0000) begin
      errors++; $display("FAIL load_use_clear: got %b expected 0000", {sf0, sd0, fe0, fd0});
    end
    drive_idle();
  endtask

  task automatic test_branch();
    @(posedge clk); #1;
    branch_taken_e = 1;
    @(negedge clk); checks++;
    if ({fd0, fe0, sf0} !== 3'b110) begin
      errors++; $display("FAIL branch: got FD,FE,SF=%b expected 110", {fd0, fe0, sf0});
    end
    @(posedge clk); #1;
    branch_taken_e = 0; pc_src_e = 1;
    @(negedge clk); checks++;
    if ({sf0, fd0, fe0} !== 3'b110) begin
      errors++; $display("FAIL pc_write: got SF,FD,FE=%b expected 110", {sf0, fd0, fe0});
    end
    drive_idle();
  endtask

  task automatic test_mem_wait();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      mem_busy_m = 1; branch_taken_e = 1;
      @(negedge clk); checks++;
      if ({sf0, sd0, se0, sm0, fw0, fe0, sf1, fw1, fe1} !== 9'b111110110) begin
        errors++;
        $display("FAIL mem_wait c%0d: got %b expected 111110110", c, {sf0, sd0, se0, sm0, fw0, fe0, sf1, fw1, fe1});
      end
    end
    @(posedge clk); #1;
    mem_busy_m = 0;
    @(negedge clk); checks++;
    if ({err0, err1, sm0, sm1, fe0, fe1, fd0} !== 7'b0000111) begin
      errors++; $display("FAIL mem_release: got %b expected 0000111", {err0, err1, sm0, sm1, fe0, fe1, fd0});
    end
    drive_idle();
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk); #1;
      mem_busy_m = 1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== model_vec(k)) begin
          errors++; $display("FAIL timeout[%0d] c%0d: got %h expected %h", k, j, dut_vec(k), model_vec(k));
        end
      end
      if (j == 5 || j == 6) begin
        checks++;
        if (err1 !== (j == 6)) begin errors++; $display("FAIL timeout_edge c%0d: got %b expected %b", j, err1, j == 6); end
      end
      if (j == 17 || j == 18) begin
        checks++;
        if (err0 !== (j == 18)) begin errors++; $display("FAIL timeout16_edge c%0d: got %b expected %b", j, err0, j == 18); end
      end
    end
    @(posedge clk); #1;
    mem_busy_m = 0;
    @(negedge clk); checks++;
    if ({err0, err1, sf0, sf1, sm0, sm1, fw1} !== 7'b1111111) begin
      errors++; $display("FAIL err_sticky: got %b expected 1111111", {err0, err1, sf0, sf1, sm0, sm1, fw1});
    end
    #2; reset = 1'b1;
    #1; checks++;
    if ({err0, err1, sm0, sm1, scnt0, fcnt0, scnt1, fcnt1} !== 44'd0) begin
      errors++; $display("FAIL async_reset: got %h expected 0", {err0, err1, sm0, sm1, scnt0, fcnt0, scnt1, fcnt1});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int j = 1; j <= 25; j++) begin
      @(posedge clk); #1;
      pc_src_d = 1;
      @(negedge clk);
      if (j == 21 || j == 25) begin
        checks++;
        if (scnt1 !== 4'd15 || scnt0 !== 16'(j - 1) || fcnt1 !== 4'd15) begin
          errors++;
          $display("FAIL saturate c%0d: got s=%0d f=%0d wide=%0d expected 15 15 %0d", j, scnt1, fcnt1, scnt0, j - 1);
        end
      end
    end
    drive_idle();
  endtask

  task automatic test_random();
    int busy_pct;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      busy_pct = ((c / 50) % 2 == 0) ? 12 : 85;
      @(posedge clk); #1;
      drive_random(busy_pct);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== model_vec(k)) begin
          errors++; $display("FAIL random[%0d] c%0d: got %h expected %h", k, c, dut_vec(k), model_vec(k));
        end
      end
      if (c % 150 == 149) begin
        #1; reset = 1'b1;
        #2; reset = 1'b0;
      end
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
